// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// sitting in the memory stage. Hits return data combinationally; misses and
// stores hold the pipeline through `stall` while a request/ack transaction
// runs against main memory.
module dcache_responder #(
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              load,
  input  logic              WMEM,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [29:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  // Remembers that the last cycle was a refill, so the hit that completes the
  // missed load is not counted as a first-lookup hit.
  logic               prev_fetch_reg;
  logic [LINES-1:0]   valid_reg;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [31:0]        word_rd [4];
  logic [CNT_W-1:0]   hit_count_reg;
  logic [CNT_W-1:0]   access_count_reg;

  // Address fields; byte-lane bits are don't-care for word accesses.
  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         unused_addr_bits;

  assign offset           = addr[3:2];
  assign index            = addr[4+INDEX_W-1:4];
  assign tag              = addr[31:4+INDEX_W];
  assign unused_addr_bits = addr[1:0];

  logic hit;
  logic fill_en;
  logic wr_hit_en;
  logic access_fire;
  logic hit_fire;

  assign hit       = valid_reg[index] && (tag_mem[index] == tag);
  // Refill lands on the ack edge; request inputs are still held so index/tag
  // still describe the missed line.
  assign fill_en   = (state_reg == FETCH) && mem_ack;
  // Write-through updates the cached copy only when the line is resident.
  assign wr_hit_en = (state_reg == WRITE) && mem_ack && hit;

  // Valid bits are the only storage that must be cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (fill_en) begin
      valid_reg[index] <= 1'b1;
    end
  end

  // Tag array: written on refill only, read asynchronously for the hit test.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index] <= tag;
    end
  end

  // One word array per block offset, so a store touches a single word and a
  // refill writes all four in parallel.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] word_mem [LINES];

      // Per-offset data storage: refill takes priority over a store update.
      always_ff @(posedge clk) begin
        if (fill_en) begin
          word_mem[index] <= mem_rdata[32*gi +: 32];
        end else if (wr_hit_en && (offset == 2'(gi))) begin
          word_mem[index] <= wdata;
        end
      end

      assign word_rd[gi] = word_mem[index];
    end
  endgenerate

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      prev_fetch_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_fetch_reg <= (state_reg == FETCH);
    end
  end

  // Next-state and output decode; a simultaneous load+store is a store.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    rdata      = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        if (WMEM) begin
          stall      = 1'b1;
          state_next = WRITE;
        end else if (load) begin
          if (hit) begin
            rdata = word_rd[offset];
          end else begin
            stall      = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {tag, index, 2'b00};
        stall    = 1'b1;
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr[31:2];
        mem_wdata = wdata;
        // The pipeline advances on the ack edge, so the store is complete
        // there and must not hold the stage any longer.
        stall     = !mem_ack;
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign access_fire = (load || WMEM) && !stall;
  assign hit_fire    = (state_reg == IDLE) && load && !WMEM && hit && !prev_fetch_reg;

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg    <= '0;
      access_count_reg <= '0;
    end else begin
      if (access_fire) begin
        access_count_reg <= access_count_reg + 1'b1;
      end
      if (hit_fire) begin
        hit_count_reg <= hit_count_reg + 1'b1;
      end
    end
  end

  assign hit_count    = hit_count_reg;
  assign access_count = access_count_reg;

endmodule
